// File: rtl/panel_scan_ctrl_if.sv
// panel_scan_ctrl_if: frame-buffer read port plus HUB75 panel connector bundle.
// Latency: wires only; timing is set by the controller.
// Backpressure: none, the panel and buffer always accept/return data.
// Signals:
//   fb_x/fb_y1/fb_y2 : buffer column / upper row / lower row address
//   fb_c1/fb_c2      : pixels returned combinationally by the buffer
//   panel_rgb1/2     : {B,G,R} shift data, panel_clk shift clock
//   panel_lat        : latch strobe (high), panel_oe_n output enable (low)
//   panel_addr       : row select A..D, frame_done end-of-frame pulse
// Modports: master = scan controller, slave = buffer/panel side.
interface panel_scan_ctrl_if #(
    parameter int XW = 6,
    parameter int YW = 5,
    parameter int AW = 4
);
    logic [XW-1:0] fb_x;
    logic [YW-1:0] fb_y1;
    logic [YW-1:0] fb_y2;
    logic [2:0]    fb_c1;
    logic [2:0]    fb_c2;
    logic [2:0]    panel_rgb1;
    logic [2:0]    panel_rgb2;
    logic          panel_clk;
    logic          panel_lat;
    logic          panel_oe_n;
    logic [AW-1:0] panel_addr;
    logic          frame_done;

    modport master (
        output fb_x, fb_y1, fb_y2,
        input  fb_c1, fb_c2,
        output panel_rgb1, panel_rgb2, panel_clk, panel_lat, panel_oe_n,
        output panel_addr, frame_done
    );

    modport slave (
        input  fb_x, fb_y1, fb_y2,
        output fb_c1, fb_c2,
        input  panel_rgb1, panel_rgb2, panel_clk, panel_lat, panel_oe_n,
        input  panel_addr, frame_done
    );
endinterface

// File: rtl/panel_scan_ctrl.sv
// panel_scan_ctrl: HUB75 scan controller for a 64x32 1-bit-RGB panel.
// Latency: row period = 2*COLS shift + blank + latch + DISP_CYCLES display.
// Backpressure: none; enable=0 parks in IDLE only after the current row ends.
// Ports:
//   clk, rst_n (synchronous, active low), enable (1 = scan runs)
//   bus (master): frame-buffer read port and panel connector outputs
//   bright [3:0] : only with SCAN_DIM_EN, per-row on-time (bright+1)/16
// Optional feature macro: SCAN_DIM_EN (global brightness via oe_n duty).
module panel_scan_ctrl #(
    parameter int COLS        = 64,
    parameter int HALF_ROWS   = 16,
    parameter int DISP_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
`ifdef SCAN_DIM_EN
    input  logic [3:0] bright,
`endif
    panel_scan_ctrl_if.master bus
);
    localparam int XW  = $clog2(COLS);
    localparam int RW  = $clog2(HALF_ROWS);
    localparam int YW  = RW + 1;
    localparam int DCW = $clog2(DISP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  col_q, col_d;
    logic           phase_q, phase_d;
    logic [RW-1:0]  r_q, r_d;
    logic [DCW-1:0] disp_cnt_q, disp_cnt_d;
    logic [XW-1:0]  fb_x_q, fb_x_d;
    logic [YW-1:0]  fb_y1_q, fb_y2_q;
    logic [2:0]     rgb1_q, rgb1_d;
    logic [2:0]     rgb2_q, rgb2_d;
    logic           pclk_q, pclk_d;
    logic           lat_q, lat_d;
    logic           oe_n_q, oe_n_d;
    logic [RW-1:0]  addr_q, addr_d;
    logic           done_q, done_d;

`ifdef SCAN_DIM_EN
    logic [3:0]     bright_q, bright_d;
    logic [3:0]     bright_sel;
    logic [DCW-1:0] on_cnt;

    // In LATCH the new brightness is being captured this edge, so the first
    // DISPLAY cycle must already use the live input rather than the register.
    always_comb begin
        bright_sel = (state_q == S_LATCH) ? bright : bright_q;
        on_cnt     = DCW'(((32'(bright_sel) + 32'd1) * 32'(DISP_CYCLES)) / 32'd16);
    end
`endif

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        phase_d    = phase_q;
        r_d        = r_q;
        disp_cnt_d = disp_cnt_q;
        fb_x_d     = fb_x_q;
        rgb1_d     = rgb1_q;
        rgb2_d     = rgb2_q;
        pclk_d     = 1'b0;
        lat_d      = 1'b0;
        oe_n_d     = oe_n_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
`ifdef SCAN_DIM_EN
        bright_d   = bright_q;
`endif

        case (state_q)
            S_IDLE: begin
                oe_n_d = 1'b1;
                fb_x_d = '0;
                if (enable) begin
                    // fb_x is already 0, so the buffer output is column 0.
                    state_d = S_SHIFT;
                    col_d   = '0;
                    phase_d = 1'b0;
                    rgb1_d  = bus.fb_c1;
                    rgb2_d  = bus.fb_c2;
                end
            end

            S_SHIFT: begin
                oe_n_d = 1'b1;
                if (!phase_q) begin
                    // Rising panel_clk with data held; advance the read
                    // address so the next column is ready one cycle early.
                    // On the last column this wraps to 0 naturally.
                    phase_d = 1'b1;
                    pclk_d  = 1'b1;
                    fb_x_d  = col_q + 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (col_q == XW'(COLS - 1)) begin
                        state_d = S_BLANK;
                        fb_x_d  = '0;
                    end else begin
                        col_d  = col_q + 1'b1;
                        rgb1_d = bus.fb_c1;
                        rgb2_d = bus.fb_c2;
                    end
                end
            end

            S_BLANK: begin
                state_d = S_LATCH;
                oe_n_d  = 1'b1;
                lat_d   = 1'b1;
                addr_d  = r_q;
            end

            S_LATCH: begin
                state_d    = S_DISPLAY;
                disp_cnt_d = '0;
`ifdef SCAN_DIM_EN
                bright_d   = bright;
                oe_n_d     = (on_cnt == '0);
`else
                oe_n_d     = 1'b0;
`endif
            end

            S_DISPLAY: begin
                if (disp_cnt_q == DCW'(DISP_CYCLES - 1)) begin
                    // Row finished: advance the scan row, flag frame wrap.
                    oe_n_d = 1'b1;
                    if (r_q == RW'(HALF_ROWS - 1)) begin
                        r_d    = '0;
                        done_d = 1'b1;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                    if (enable) begin
                        state_d = S_SHIFT;
                        col_d   = '0;
                        phase_d = 1'b0;
                        rgb1_d  = bus.fb_c1;
                        rgb2_d  = bus.fb_c2;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    disp_cnt_d = disp_cnt_q + 1'b1;
`ifdef SCAN_DIM_EN
                    oe_n_d = !((disp_cnt_q + 1'b1) < on_cnt);
`else
                    oe_n_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
                oe_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            phase_q    <= 1'b0;
            r_q        <= '0;
            disp_cnt_q <= '0;
            fb_x_q     <= '0;
            fb_y1_q    <= '0;
            fb_y2_q    <= YW'(HALF_ROWS);
            rgb1_q     <= '0;
            rgb2_q     <= '0;
            pclk_q     <= 1'b0;
            lat_q      <= 1'b0;
            oe_n_q     <= 1'b1;
            addr_q     <= '0;
            done_q     <= 1'b0;
`ifdef SCAN_DIM_EN
            bright_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            phase_q    <= phase_d;
            r_q        <= r_d;
            disp_cnt_q <= disp_cnt_d;
            fb_x_q     <= fb_x_d;
            // r only moves on the DISPLAY exit edge, so these follow it there.
            fb_y1_q    <= YW'(r_d);
            fb_y2_q    <= YW'(r_d) + YW'(HALF_ROWS);
            rgb1_q     <= rgb1_d;
            rgb2_q     <= rgb2_d;
            pclk_q     <= pclk_d;
            lat_q      <= lat_d;
            oe_n_q     <= oe_n_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
`ifdef SCAN_DIM_EN
            bright_q   <= bright_d;
`endif
        end
    end

    assign bus.fb_x       = fb_x_q;
    assign bus.fb_y1      = fb_y1_q;
    assign bus.fb_y2      = fb_y2_q;
    assign bus.panel_rgb1 = rgb1_q;
    assign bus.panel_rgb2 = rgb2_q;
    assign bus.panel_clk  = pclk_q;
    assign bus.panel_lat  = lat_q;
    assign bus.panel_oe_n = oe_n_q;
    assign bus.panel_addr = addr_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_panel_scan_ctrl.sv
// tb_panel_scan_ctrl: directed bench for panel_scan_ctrl.
// Buffer model returns fb_c1 = x[2:0], fb_c2 = ~x[2:0].
// Outputs are sampled on the falling edge of clk.
module tb_panel_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic enable;
`ifdef SCAN_DIM_EN
    logic [3:0] bright;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc_last = 0;
    int done_cyc_prev = 0;

    localparam logic [29:0] RESET_VEC =
        {6'd0, 5'd0, 5'd16, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};

    panel_scan_ctrl_if bus ();

    assign bus.fb_c1 = bus.fb_x[2:0];
    assign bus.fb_c2 = ~bus.fb_x[2:0];

    panel_scan_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
`ifdef SCAN_DIM_EN
        .bright (bright),
`endif
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) begin
            done_cyc_prev = done_cyc_last;
            done_cyc_last = cyc;
            done_cnt++;
        end
    end

    function automatic logic [29:0] out_vec();
        return {bus.fb_x, bus.fb_y1, bus.fb_y2, bus.panel_rgb1, bus.panel_rgb2,
                bus.panel_clk, bus.panel_lat, bus.panel_oe_n, bus.panel_addr,
                bus.frame_done};
    endfunction

    // Observe one row: shift until the latch strobe, then the display window.
    // drop_at: shift-step at which enable is lowered (-1 = never).
    // rst_at : display cycle at which rst_n is asserted and the task returns.
    task automatic next_row(input int drop_at, input int rst_at,
                            output int addr, output int rises, output int rgb_errs,
                            output logic lat_after, output int oe_low,
                            output int lat_cyc, output bit timeout);
        logic       prev;
        logic [2:0] kx;
        int         n;
        prev = bus.panel_clk;
        rises = 0; rgb_errs = 0; n = 0; timeout = 0;
        addr = -1; lat_after = 1'bx; oe_low = 0; lat_cyc = 0;
        while (bus.panel_lat !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n == drop_at) enable = 1'b0;
            if (bus.panel_clk === 1'b1 && prev === 1'b0) begin
                kx = rises[2:0];
                if (bus.panel_rgb1 !== kx || bus.panel_rgb2 !== ~kx) rgb_errs++;
                rises++;
            end
            prev = bus.panel_clk;
            if (n > 600) begin
                timeout = 1;
                return;
            end
        end
        addr    = int'(bus.panel_addr);
        lat_cyc = cyc;
        @(negedge clk);
        lat_after = bus.panel_lat;
        while (bus.panel_oe_n === 1'b0) begin
            oe_low++;
            if (oe_low == rst_at) begin
                rst_n = 1'b0;
                return;
            end
            @(negedge clk);
            if (oe_low > 600) begin
                timeout = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_vec() !== RESET_VEC) begin
            failures++;
            $display("FAIL reset_values got=%h want=%h", out_vec(), RESET_VEC);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (out_vec() !== RESET_VEC) begin
            failures++;
            $display("FAIL idle_hold got=%h want=%h", out_vec(), RESET_VEC);
        end
    endtask

    task automatic test_scan_rows();
        int addr, rises, errs, oe_low, lat_cyc, prev_lat, base;
        logic lat_after;
        bit to;
        base = done_cnt;
        prev_lat = 0;
        enable = 1'b1;
        for (int row = 0; row < 33; row++) begin
            next_row(-1, -1, addr, rises, errs, lat_after, oe_low, lat_cyc, to);
            checks++;
            if (to) begin
                failures++;
                $display("FAIL row_timeout row=%0d", row);
            end
            checks++;
            if (addr != row % 16) begin
                failures++;
                $display("FAIL row_addr row=%0d got=%0d want=%0d", row, addr, row % 16);
            end
            checks++;
            if (rises != 64) begin
                failures++;
                $display("FAIL clk_rises row=%0d got=%0d want=64", row, rises);
            end
            checks++;
            if (errs != 0) begin
                failures++;
                $display("FAIL rgb_data row=%0d bad_columns=%0d want=0", row, errs);
            end
            checks++;
            if (lat_after !== 1'b0) begin
                failures++;
                $display("FAIL lat_width row=%0d lat_next=%b want=0", row, lat_after);
            end
            checks++;
            if (oe_low != 256) begin
                failures++;
                $display("FAIL oe_low row=%0d got=%0d want=256", row, oe_low);
            end
            if (row > 0) begin
                checks++;
                if (lat_cyc - prev_lat != 386) begin
                    failures++;
                    $display("FAIL row_period row=%0d got=%0d want=386", row, lat_cyc - prev_lat);
                end
            end
            checks++;
            if (bus.frame_done !== (row % 16 == 15)) begin
                failures++;
                $display("FAIL frame_done row=%0d got=%b want=%b", row, bus.frame_done, row % 16 == 15);
            end
            prev_lat = lat_cyc;
        end
        checks++;
        if (done_cnt - base != 2) begin
            failures++;
            $display("FAIL frame_pulses got=%0d want=2", done_cnt - base);
        end
        checks++;
        if (done_cyc_last - done_cyc_prev != 6176) begin
            failures++;
            $display("FAIL frame_period got=%0d want=6176", done_cyc_last - done_cyc_prev);
        end
    endtask

    task automatic test_enable_drop();
        int addr, rises, errs, oe_low, lat_cyc;
        int idle_rises, idle_lat, idle_oe, idle_fbx;
        logic lat_after, prev;
        bit to;
        for (int row = 1; row <= 4; row++) begin
            next_row(-1, -1, addr, rises, errs, lat_after, oe_low, lat_cyc, to);
            checks++;
            if (to || addr != row) begin
                failures++;
                $display("FAIL pre_drop_addr got=%0d want=%0d timeout=%0b", addr, row, to);
            end
        end
        next_row(30, -1, addr, rises, errs, lat_after, oe_low, lat_cyc, to);
        checks++;
        if (to || addr != 5) begin
            failures++;
            $display("FAIL drop_row_addr got=%0d want=5 timeout=%0b", addr, to);
        end
        checks++;
        if (rises != 64 || oe_low != 256) begin
            failures++;
            $display("FAIL drop_row_complete rises=%0d oe_low=%0d want=64/256", rises, oe_low);
        end
        idle_rises = 0; idle_lat = 0; idle_oe = 0; idle_fbx = 0;
        prev = bus.panel_clk;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.panel_clk === 1'b1 && prev === 1'b0) idle_rises++;
            prev = bus.panel_clk;
            if (bus.panel_lat !== 1'b0) idle_lat++;
            if (bus.panel_oe_n !== 1'b1) idle_oe++;
            if (bus.fb_x !== 6'd0) idle_fbx++;
        end
        checks++;
        if (idle_rises != 0 || idle_lat != 0) begin
            failures++;
            $display("FAIL idle_activity rises=%0d lat=%0d want=0/0", idle_rises, idle_lat);
        end
        checks++;
        if (idle_oe != 0 || idle_fbx != 0) begin
            failures++;
            $display("FAIL idle_blank oe_low_cycles=%0d fbx_nonzero=%0d want=0/0", idle_oe, idle_fbx);
        end
        enable = 1'b1;
        next_row(-1, -1, addr, rises, errs, lat_after, oe_low, lat_cyc, to);
        checks++;
        if (to || addr != 6) begin
            failures++;
            $display("FAIL resume_addr got=%0d want=6 timeout=%0b", addr, to);
        end
        checks++;
        if (rises != 64 || errs != 0) begin
            failures++;
            $display("FAIL resume_shift rises=%0d rgb_bad=%0d want=64/0", rises, errs);
        end
    endtask

    task automatic test_reset_mid_display();
        int addr, rises, errs, oe_low, lat_cyc;
        logic lat_after;
        bit to;
        for (int row = 7; row <= 8; row++) begin
            next_row(-1, -1, addr, rises, errs, lat_after, oe_low, lat_cyc, to);
            checks++;
            if (to || addr != row) begin
                failures++;
                $display("FAIL pre_reset_addr got=%0d want=%0d timeout=%0b", addr, row, to);
            end
        end
        next_row(-1, 100, addr, rises, errs, lat_after, oe_low, lat_cyc, to);
        checks++;
        if (to || addr != 9 || oe_low != 100) begin
            failures++;
            $display("FAIL reset_row got_addr=%0d oe_low=%0d want=9/100", addr, oe_low);
        end
        @(negedge clk);
        checks++;
        if (out_vec() !== RESET_VEC) begin
            failures++;
            $display("FAIL mid_display_reset got=%h want=%h", out_vec(), RESET_VEC);
        end
        rst_n = 1'b1;
        next_row(-1, -1, addr, rises, errs, lat_after, oe_low, lat_cyc, to);
        checks++;
        if (to || addr != 0) begin
            failures++;
            $display("FAIL restart_addr got=%0d want=0 timeout=%0b", addr, to);
        end
        checks++;
        if (rises != 64 || errs != 0 || oe_low != 256) begin
            failures++;
            $display("FAIL restart_row rises=%0d rgb_bad=%0d oe_low=%0d want=64/0/256",
                     rises, errs, oe_low);
        end
    endtask

`ifdef SCAN_DIM_EN
    task automatic test_dimming();
        int addr, rises, errs, oe_low, lat_cyc, prev_lat;
        logic lat_after;
        bit to;
        bright = 4'd3;
        next_row(-1, -1, addr, rises, errs, lat_after, oe_low, lat_cyc, to);
        checks++;
        if (to || oe_low != 64) begin
            failures++;
            $display("FAIL dim_bright3 oe_low=%0d want=64", oe_low);
        end
        prev_lat = lat_cyc;
        next_row(-1, -1, addr, rises, errs, lat_after, oe_low, lat_cyc, to);
        checks++;
        if (to || lat_cyc - prev_lat != 386) begin
            failures++;
            $display("FAIL dim_period got=%0d want=386", lat_cyc - prev_lat);
        end
        bright = 4'd15;
        next_row(-1, -1, addr, rises, errs, lat_after, oe_low, lat_cyc, to);
        checks++;
        if (to || oe_low != 256) begin
            failures++;
            $display("FAIL dim_bright15 oe_low=%0d want=256", oe_low);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SCAN_DIM_EN
        bright = 4'd15;
`endif
        test_reset();
        test_scan_rows();
        test_enable_drop();
        test_reset_mid_display();
`ifdef SCAN_DIM_EN
        test_dimming();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
